// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths and FSM state encodings for the memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned BUS_ADDR_WIDTH = 32;
    localparam int unsigned BUS_DATA_WIDTH = 32;
    localparam int unsigned ARB_STATE_WIDTH = 2;

    typedef enum logic [ARB_STATE_WIDTH-1:0] {
        ARB_IDLE = 2'd0,
        ARB_DATA = 2'd1,
        ARB_INST = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one external memory bus between instruction fetch and data access.
// Data wins over fetch; each result is held with its done flag until the
// pipeline advances (both stalls low), so a completed port is never re-issued.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = BUS_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    inst_en,
    input  logic [ADDR_WIDTH-1:0]   inst_addr,
    output logic [DATA_WIDTH-1:0]   inst_rdata,
    output logic                    inst_stall,

    input  logic                    data_en,
    input  logic [DATA_WIDTH/8-1:0] data_write_en,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    data_stall,

    output logic                    bus_en,
    output logic [DATA_WIDTH/8-1:0] bus_write_en,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_ready,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    arb_state_e state;
    arb_state_e state_next;

    logic inst_done;
    logic data_done;
    logic inst_done_next;
    logic data_done_next;
    logic pipe_advance;

    logic                  bus_en_next;
    logic [STRB_WIDTH-1:0] bus_write_en_next;
    logic [ADDR_WIDTH-1:0] bus_addr_next;
    logic [DATA_WIDTH-1:0] bus_wdata_next;
    logic [DATA_WIDTH-1:0] inst_rdata_next;
    logic [DATA_WIDTH-1:0] data_rdata_next;

    // Stalls follow the requests combinationally; a set done flag hides the request.
    assign inst_stall   = inst_en & ~inst_done;
    assign data_stall   = data_en & ~data_done;
    assign pipe_advance = ~inst_stall & ~data_stall;

    // State register plus all registered outputs and done flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ARB_IDLE;
            inst_done    <= 1'b0;
            data_done    <= 1'b0;
            bus_en       <= 1'b0;
            bus_write_en <= '0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            inst_rdata   <= '0;
            data_rdata   <= '0;
        end else begin
            state        <= state_next;
            inst_done    <= inst_done_next;
            data_done    <= data_done_next;
            bus_en       <= bus_en_next;
            bus_write_en <= bus_write_en_next;
            bus_addr     <= bus_addr_next;
            bus_wdata    <= bus_wdata_next;
            inst_rdata   <= inst_rdata_next;
            data_rdata   <= data_rdata_next;
        end
    end

    // Next-state: issue pending data before fetch, return to IDLE on bus_ready.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (data_stall) begin
                    state_next = ARB_DATA;
                end else if (inst_stall) begin
                    state_next = ARB_INST;
                end
            end
            ARB_DATA, ARB_INST: begin
                if (bus_ready) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Output/next-register values: latch bus request, capture results, manage done flags.
    always_comb begin
        bus_en_next       = bus_en;
        bus_write_en_next = bus_write_en;
        bus_addr_next     = bus_addr;
        bus_wdata_next    = bus_wdata;
        inst_rdata_next   = inst_rdata;
        data_rdata_next   = data_rdata;
        inst_done_next    = inst_done;
        data_done_next    = data_done;

        if (pipe_advance) begin
            inst_done_next = 1'b0;
            data_done_next = 1'b0;
        end

        case (state)
            ARB_IDLE: begin
                if (data_stall) begin
                    bus_en_next       = 1'b1;
                    bus_write_en_next = data_write_en;
                    bus_addr_next     = data_addr;
                    bus_wdata_next    = data_wdata;
                end else if (inst_stall) begin
                    bus_en_next       = 1'b1;
                    bus_write_en_next = '0;
                    bus_addr_next     = inst_addr;
                end
            end
            ARB_DATA: begin
                if (bus_ready) begin
                    bus_en_next    = 1'b0;
                    data_done_next = 1'b1;
                    if (bus_write_en == '0) begin
                        data_rdata_next = bus_rdata;
                    end
                end
            end
            ARB_INST: begin
                if (bus_ready) begin
                    bus_en_next     = 1'b0;
                    inst_done_next  = 1'b1;
                    inst_rdata_next = bus_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule
